// File: rtl/fir_mac_ctrl_pkg.sv
// Shared defaults and FSM encoding for the FIR sequencer/MAC stage.
// Imported by the controller and its round/saturate helper.
package fir_mac_ctrl_pkg;

  localparam int NTAPS_D     = 64;
  localparam int WIDTH_D     = 16;
  localparam int ADDR_W_D    = 6;
  localparam int ACC_W_D     = 2 * WIDTH_D + ADDR_W_D;
  localparam int OUT_SHIFT_D = 15;

  typedef enum logic [2:0] {
    S_CLR   = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_MAC   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and saturate an accumulator to WIDTH.
// Purely combinational so later output stages can reuse it.
module fir_round_sat
  import fir_mac_ctrl_pkg::*;
#(
  parameter int ACC_W     = ACC_W_D,
  parameter int WIDTH     = WIDTH_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [WIDTH-1:0]        y,
  output logic                    sat
);

  localparam int RW = ACC_W + 1;

  localparam logic signed [RW-1:0] HALF =
    {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV =
    {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [RW-1:0] r;
  logic signed [RW-1:0] s;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    r   = {acc[ACC_W-1], acc} + HALF;
    s   = r >>> OUT_SHIFT;
    y   = s[WIDTH-1:0];
    sat = 1'b0;
    if (s > MAXV) begin
      y   = MAXV[WIDTH-1:0];
      sat = 1'b1;
    end else if (s < MINV) begin
      y   = MINV[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR sequencer/MAC: writes samples into a circular regfile, walks
// NTAPS sample/coef pairs and emits one rounded, saturated output.
module fir_mac_ctrl
  import fir_mac_ctrl_pkg::*;
#(
  parameter int NTAPS     = NTAPS_D,
  parameter int WIDTH     = WIDTH_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int ACC_W     = ACC_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_sample,
  output logic              smp_wen,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [WIDTH-1:0]  smp_din,
  output logic              smp_ren,
  output logic [ADDR_W-1:0] smp_raddr,
  input  logic [WIDTH-1:0]  smp_dout,
  output logic              coef_ren,
  output logic [ADDR_W-1:0] coef_raddr,
  input  logic [WIDTH-1:0]  coef_dout,
  output logic              out_valid,
  output logic [WIDTH-1:0]  y,
  output logic              sat
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);
  localparam logic [ADDR_W-1:0] NTA  = ADDR_W'(NTAPS);

  state_t st, nst;

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] base;
  logic [WIDTH-1:0]  smp;
  logic              pv;
  logic              cnt_last;

  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_x;

  logic [WIDTH-1:0] ry;
  logic             rsat;

  assign cnt_last = (cnt == LAST);

  assign prod   = $signed(smp_dout) * $signed(coef_dout);
  assign prod_x = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .WIDTH     (WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rs (
    .acc (acc),
    .y   (ry),
    .sat (rsat)
  );

  always_comb begin
    nst = st;
    unique case (st)
      S_CLR:   if (cnt_last) nst = S_IDLE;
      S_IDLE: begin
        if (clr)           nst = S_CLR;
        else if (in_valid) nst = S_WRITE;
      end
      S_WRITE: nst = S_MAC;
      S_MAC:   if (cnt_last) nst = S_DRAIN;
      S_DRAIN: if (cnt[0]) nst = S_IDLE;
      default: nst = S_CLR;
    endcase
  end

  // Regfile port decode; smp_wen is gated so reset forces it low at once.
  always_comb begin
    in_ready   = 1'b0;
    smp_wen    = 1'b0;
    smp_waddr  = '0;
    smp_din    = '0;
    smp_ren    = 1'b0;
    smp_raddr  = '0;
    coef_ren   = 1'b0;
    coef_raddr = '0;
    unique case (1'b1)
      (st == S_CLR): begin
        smp_wen   = ~rst;
        smp_waddr = cnt;
      end
      (st == S_IDLE): in_ready = 1'b1;
      (st == S_WRITE): begin
        smp_wen   = 1'b1;
        smp_waddr = wptr;
        smp_din   = smp;
      end
      (st == S_MAC): begin
        smp_ren    = 1'b1;
        coef_ren   = 1'b1;
        coef_raddr = cnt;
        smp_raddr  = (cnt > base) ? base - cnt + NTA
                                  : base - cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      st        <= S_CLR;
      cnt       <= '0;
      wptr      <= '0;
      base      <= '0;
      smp       <= '0;
      pv        <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
    end else begin
      st        <= nst;
      out_valid <= 1'b0;
      pv        <= (st == S_MAC);
      if (pv) acc <= acc + prod_x;
      unique case (st)
        S_CLR: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last) wptr <= '0;
        end
        S_IDLE: begin
          if (!clr && in_valid) smp <= in_sample;
        end
        S_WRITE: begin
          acc  <= '0;
          base <= wptr;
          wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
          cnt  <= '0;
        end
        S_MAC: cnt <= cnt_last ? '0 : cnt + 1'b1;
        // First drain cycle absorbs the last product, second registers y.
        S_DRAIN: begin
          if (cnt[0]) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            y         <= ry;
            sat       <= rsat;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Scoreboard bench for fir_mac_ctrl with behavioural regfiles and a
// sample-history reference model.
module tb_fir_mac_ctrl;

  localparam int NT = 64;

  logic        clk2 = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_sample = '0;
  logic        in_ready;
  logic        smp_wen;
  logic [5:0]  smp_waddr;
  logic [15:0] smp_din;
  logic        smp_ren;
  logic [5:0]  smp_raddr;
  logic [15:0] smp_dout = '0;
  logic        coef_ren;
  logic [5:0]  coef_raddr;
  logic [15:0] coef_dout = '0;
  logic        out_valid;
  logic [15:0] y;
  logic        sat;

  int checks = 0;
  int errors = 0;

  logic [15:0] smem [NT];
  logic [15:0] cmem [NT];

  typedef struct {
    logic [15:0] y;
    logic        sat;
  } exp_t;

  exp_t q[$];
  int   hist [NT];

  fir_mac_ctrl dut (
    .clk2       (clk2),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .smp_wen    (smp_wen),
    .smp_waddr  (smp_waddr),
    .smp_din    (smp_din),
    .smp_ren    (smp_ren),
    .smp_raddr  (smp_raddr),
    .smp_dout   (smp_dout),
    .coef_ren   (coef_ren),
    .coef_raddr (coef_raddr),
    .coef_dout  (coef_dout),
    .out_valid  (out_valid),
    .y          (y),
    .sat        (sat)
  );

  always #5 clk2 = ~clk2;

  // Registered-read regfiles
  always @(posedge clk2) begin
    if (smp_wen) smem[smp_waddr] <= smp_din;
    if (smp_ren) smp_dout <= smem[smp_raddr];
    if (coef_ren) coef_dout <= cmem[coef_raddr];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NT; i++) hist[i] = 0;
  endfunction

  // y[n] = sat(round(sum_k c[k]*x[n-k] / 2^15))
  function automatic void model_push(input logic [15:0] x);
    longint a;
    longint r;
    exp_t   e;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'($signed(x));
    a = 0;
    for (int k = 0; k < NT; k++)
      a += longint'(hist[k]) * longint'($signed(cmem[k]));
    r = (a + 64'sd16384) >>> 15;
    if (r > 32767) begin
      e.y = 16'h7FFF; e.sat = 1'b1;
    end else if (r < -32768) begin
      e.y = 16'h8000; e.sat = 1'b1;
    end else begin
      e.y = r[15:0]; e.sat = 1'b0;
    end
    q.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk2) begin
    if (!rst) begin
      if (smp_wen || smp_ren)
        chk("wen_ren_excl", longint'(smp_wen & smp_ren), 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got y=%h expected none", y);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("y", longint'(y), longint'(e.y));
          chk("sat", longint'(sat), longint'(e.sat));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk2);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk2);
      n++;
    end
    @(negedge clk2);
    if (q.size() != 0 || !in_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] x);
    wait_ready();
    in_valid  = 1'b1;
    in_sample = x;
    model_push(x);
    @(posedge clk2);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_impulse_coefs();
    for (int i = 0; i < NT; i++) cmem[i] = '0;
    cmem[0] = 16'h4000;
    cmem[1] = 16'h2000;
  endtask

  task automatic impulse_test(input string tag);
    logic [15:0] xs [3];
    logic [15:0] ys [3];
    xs[0] = 16'h4000; xs[1] = 16'h0000; xs[2] = 16'h0000;
    ys[0] = 16'h2000; ys[1] = 16'h1000; ys[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      send(xs[i]);
      wait_idle();
      chk({tag, "_y"}, longint'(y), longint'(ys[i]));
      chk({tag, "_sat"}, longint'(sat), 0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nz;
    for (int i = 0; i < NT; i++) begin
      smem[i] = 16'($urandom);
      cmem[i] = '0;
    end
    model_clear();
    #2 rst = 1'b1;

    // Reset state and initial clear
    @(negedge clk2);
    #1;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_smp_wen", longint'(smp_wen), 0);
    chk("rst_smp_ren", longint'(smp_ren), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_y", longint'(y), 0);
    @(negedge clk2);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NT; i++) begin
      chk("clr_in_ready", longint'(in_ready), 0);
      chk("clr_wen", longint'(smp_wen), 1);
      chk("clr_waddr", longint'(smp_waddr), longint'(i));
      chk("clr_din", longint'(smp_din), 0);
      @(negedge clk2);
    end
    chk("clr_done_ready", longint'(in_ready), 1);
    nz = 0;
    for (int i = 0; i < NT; i++) if (smem[i] != 0) nz++;
    chk("clr_mem_zero", longint'(nz), 0);

    // Impulse response
    set_impulse_coefs();
    impulse_test("imp1");

    // Latency and in_ready window
    send(16'h4000);
    for (int j = 0; j <= 66; j++) begin
      @(negedge clk2);
      chk("lat_in_ready", longint'(in_ready), 0);
      chk("lat_out_valid", longint'(out_valid), 0);
    end
    @(negedge clk2);
    chk("lat_pulse", longint'(out_valid), 1);
    chk("lat_ready_back", longint'(in_ready), 1);
    @(negedge clk2);
    chk("lat_pulse_end", longint'(out_valid), 0);

    // Positive and negative full-scale saturation
    for (int i = 0; i < NT; i++) cmem[i] = 16'h7FFF;
    for (int i = 0; i < NT; i++) send(16'h7FFF);
    wait_idle();
    chk("satp_y", longint'(y), 16'h7FFF);
    chk("satp_sat", longint'(sat), 1);
    for (int i = 0; i < NT; i++) send(16'h8000);
    wait_idle();
    chk("satn_y", longint'(y), 16'h8000);
    chk("satn_sat", longint'(sat), 1);

    // Single delayed tap across wptr wrap
    for (int i = 0; i < NT; i++) cmem[i] = '0;
    cmem[1] = 16'h4000;
    for (int n = 1; n <= 70; n++) send(16'(2 * n));
    wait_idle();
    chk("ramp_last_y", longint'(y), 69);
    chk("ramp_last_sat", longint'(sat), 0);

    // Reset during MAC at k=20
    for (int i = 0; i < NT; i++) cmem[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) send(16'($urandom));
    wait_idle();
    send(16'($urandom));
    repeat (22) @(negedge clk2);
    chk("mid_ren", longint'(coef_ren), 1);
    chk("mid_k", longint'(coef_raddr), 20);
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", longint'(in_ready), 0);
    chk("mrst_wen", longint'(smp_wen), 0);
    chk("mrst_ren", longint'(smp_ren), 0);
    chk("mrst_cren", longint'(coef_ren), 0);
    chk("mrst_raddr", longint'(coef_raddr), 0);
    chk("mrst_out_valid", longint'(out_valid), 0);
    chk("mrst_y", longint'(y), 0);
    q.delete();
    model_clear();
    repeat (3) @(negedge clk2);
    rst = 1'b0;
    #1;
    chk("mrst_clr_wen", longint'(smp_wen), 1);
    chk("mrst_clr_ready", longint'(in_ready), 0);
    wait_ready();

    // clr in IDLE beats a simultaneous in_valid
    for (int i = 0; i < 5; i++) send(16'($urandom));
    wait_idle();
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'h1234;
    @(posedge clk2);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_req_ready", longint'(in_ready), 0);
    chk("clr_req_wen", longint'(smp_wen), 1);
    chk("clr_req_addr", longint'(smp_waddr), 0);
    model_clear();
    wait_ready();
    set_impulse_coefs();
    impulse_test("imp2");

    // Randomized traffic
    for (int r = 0; r < 3; r++) begin
      wait_idle();
      for (int i = 0; i < NT; i++) cmem[i] = 16'($urandom_range(0, 16'hFFFF) >> r);
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk2);
        if ($urandom_range(0, 15) == 0) begin
          wait_idle();
          clr = 1'b1;
          @(posedge clk2);
          #1;
          clr = 1'b0;
          model_clear();
        end
        send(16'($urandom));
      end
    end

    wait_idle();
    chk("queue_empty", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
